// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard sequencer: stall/flush/forward-select generation for the
// ID/EX register and fetch stage, with a two-state FSM covering the second
// stall cycle of a branch that depends on a load, and saturating event counters.
module decode_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_F,
  input  logic [4:0]       rs2_F,
  input  logic             use_rs2_F,
  input  logic             branch_D,
  input  logic             MemRead_E,
  input  logic             RegWrite_E,
  input  logic [4:0]       rd_E,
  input  logic             MemRead_M,
  input  logic             RegWrite_M,
  input  logic [4:0]       rd_M,
  input  logic             mispredict_E,
  input  logic             jr_E,
  output logic             stall,
  output logic             flush,
  output logic             fwd_rs1,
  output logic             fwd_rs2,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, HOLD2 = 1'b1} state_t;

  state_t state, state_nxt;

  logic match_e, match_m;
  logic match_m_rs1, match_m_rs2;
  logic h_lu, h_ba, h_bl, h_bm;
  logic flush_req;

  // Saturating increment: counters park at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Register matches against EX and MEM producers; r0 never matches.
  always_comb begin
    match_m_rs1 = (rd_M != 5'd0) && (rd_M == rs1_F);
    match_m_rs2 = (rd_M != 5'd0) && (rd_M == rs2_F) && use_rs2_F;
    match_e     = (rd_E != 5'd0) &&
                  ((rd_E == rs1_F) || ((rd_E == rs2_F) && use_rs2_F));
    match_m     = match_m_rs1 || match_m_rs2;
  end

  // Hazard classification and control outputs; flush takes priority over stall.
  always_comb begin
    h_lu      = MemRead_E && match_e;
    h_ba      = branch_D && RegWrite_E && !MemRead_E && match_e;
    h_bl      = branch_D && MemRead_E && match_e;
    h_bm      = branch_D && MemRead_M && match_m;
    flush_req = mispredict_E || jr_E;
    flush     = flush_req && !reset;
    // In HOLD2 the load has reached MEM, so the branch still needs one more bubble.
    stall     = !reset && !flush_req &&
                ((state == HOLD2) || h_lu || h_ba || h_bl || h_bm);
    fwd_rs1   = RegWrite_M && !MemRead_M && match_m_rs1 && !flush;
    fwd_rs2   = RegWrite_M && !MemRead_M && match_m_rs2 && !flush;
    busy      = (state == HOLD2);
  end

  // Next-state logic: a redirect cancels any committed second stall.
  always_comb begin
    state_nxt = state;
    if (flush_req) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     state_nxt = h_bl ? HOLD2 : RUN;
        HOLD2:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Performance counters for stall and flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed testbench for decode_hazard_ctrl; a second instance with CNT_W=4
// shares all inputs and is used for counter saturation.
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_F, rs2_F, rd_E, rd_M;
  logic        use_rs2_F, branch_D, MemRead_E, RegWrite_E, MemRead_M, RegWrite_M;
  logic        mispredict_E, jr_E;
  logic        stall, flush, fwd_rs1, fwd_rs2, busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall4, flush4, fwd_rs1_4, fwd_rs2_4, busy4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;
  int exp_fc = 0;
  int exp_sc4 = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rs1_F(rs1_F), .rs2_F(rs2_F), .use_rs2_F(use_rs2_F),
    .branch_D(branch_D), .MemRead_E(MemRead_E), .RegWrite_E(RegWrite_E), .rd_E(rd_E),
    .MemRead_M(MemRead_M), .RegWrite_M(RegWrite_M), .rd_M(rd_M),
    .mispredict_E(mispredict_E), .jr_E(jr_E), .stall(stall), .flush(flush),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  decode_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .rs1_F(rs1_F), .rs2_F(rs2_F), .use_rs2_F(use_rs2_F),
    .branch_D(branch_D), .MemRead_E(MemRead_E), .RegWrite_E(RegWrite_E), .rd_E(rd_E),
    .MemRead_M(MemRead_M), .RegWrite_M(RegWrite_M), .rd_M(rd_M),
    .mispredict_E(mispredict_E), .jr_E(jr_E), .stall(stall4), .flush(flush4),
    .fwd_rs1(fwd_rs1_4), .fwd_rs2(fwd_rs2_4), .busy(busy4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic clr_inputs();
    rs1_F = 5'd0; rs2_F = 5'd0; use_rs2_F = 1'b0; branch_D = 1'b0;
    MemRead_E = 1'b0; RegWrite_E = 1'b0; rd_E = 5'd0;
    MemRead_M = 1'b0; RegWrite_M = 1'b0; rd_M = 5'd0;
    mispredict_E = 1'b0; jr_E = 1'b0;
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_inputs();
    mispredict_E = 1'b1;
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd5; rs1_F = 5'd5;
    RegWrite_M = 1'b1; rd_M = 5'd3; rs2_F = 5'd3; use_rs2_F = 1'b1;
    cyc(); cyc();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b expected 0", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %0b expected 0", flush); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt: got %0d expected 0", flush_cnt); end
    // Forwarding still follows inputs while in reset (flush is held low).
    checks++; if (fwd_rs2 !== 1'b1) begin errors++; $display("FAIL rst_fwd_rs2: got %0b expected 1", fwd_rs2); end
    clr_inputs();
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    cyc();
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd5; rs1_F = 5'd5;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b expected 1", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL lu_flush: got %0b expected 0", flush); end
    cyc(); exp_sc++;
    clr_inputs();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_after: got %0b expected 0", stall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lu_busy: got %0b expected 0", busy); end
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_sc); end
    // rs2 only counts when the instruction reads it.
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd6; rs2_F = 5'd6; use_rs2_F = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_rs2_unused: got %0b expected 0", stall); end
    use_rs2_F = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rs2_used: got %0b expected 1", stall); end
    // r0 never hazards.
    clr_inputs(); MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd0; rs1_F = 5'd0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_r0: got %0b expected 0", stall); end
    // Branch on ALU result in EX stalls; the same producer for a non-branch does not.
    clr_inputs(); RegWrite_E = 1'b1; rd_E = 5'd7; rs1_F = 5'd7; branch_D = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ba_stall: got %0b expected 1", stall); end
    branch_D = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ba_nobranch: got %0b expected 0", stall); end
    // Branch on a load sitting in MEM needs one stall.
    clr_inputs(); MemRead_M = 1'b1; RegWrite_M = 1'b1; rd_M = 5'd9; rs2_F = 5'd9;
    use_rs2_F = 1'b1; branch_D = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bm_stall: got %0b expected 1", stall); end
    checks++; if (fwd_rs2 !== 1'b0) begin errors++; $display("FAIL bm_no_fwd: got %0b expected 0", fwd_rs2); end
    clr_inputs();
    #1;
  endtask

  task automatic test_branch_load();
    cyc();
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd8; rs1_F = 5'd8; branch_D = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bl_stall1: got %0b expected 1", stall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bl_busy1: got %0b expected 0", busy); end
    cyc(); exp_sc++;
    // Load advanced to MEM, bubble in EX.
    MemRead_E = 1'b0; RegWrite_E = 1'b0; rd_E = 5'd0;
    MemRead_M = 1'b1; RegWrite_M = 1'b1; rd_M = 5'd8;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bl_stall2: got %0b expected 1", stall); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bl_busy2: got %0b expected 1", busy); end
    cyc(); exp_sc++;
    MemRead_M = 1'b0; RegWrite_M = 1'b0; rd_M = 5'd0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bl_stall3: got %0b expected 0", stall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bl_busy3: got %0b expected 0", busy); end
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errors++; $display("FAIL bl_stall_cnt: got %0d expected %0d", stall_cnt, exp_sc); end
    // H_BL together with H_BM still takes the two-stall path.
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd8;
    MemRead_M = 1'b1; RegWrite_M = 1'b1; rd_M = 5'd9; rs2_F = 5'd9; use_rs2_F = 1'b1;
    cyc(); exp_sc++;
    clr_inputs();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL blbm_busy: got %0b expected 1", busy); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL blbm_stall: got %0b expected 1", stall); end
    cyc(); exp_sc++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL blbm_run: got %0b expected 0", busy); end
  endtask

  task automatic test_forward();
    clr_inputs();
    RegWrite_M = 1'b1; rd_M = 5'd3; rs2_F = 5'd3; use_rs2_F = 1'b1; rs1_F = 5'd4; branch_D = 1'b1;
    #1;
    checks++; if (fwd_rs2 !== 1'b1) begin errors++; $display("FAIL fwd_rs2: got %0b expected 1", fwd_rs2); end
    checks++; if (fwd_rs1 !== 1'b0) begin errors++; $display("FAIL fwd_rs1: got %0b expected 0", fwd_rs1); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %0b expected 0", stall); end
    use_rs2_F = 1'b0;
    #1;
    checks++; if (fwd_rs2 !== 1'b0) begin errors++; $display("FAIL fwd_rs2_unused: got %0b expected 0", fwd_rs2); end
    use_rs2_F = 1'b1; rd_M = 5'd0; rs2_F = 5'd0;
    #1;
    checks++; if (fwd_rs2 !== 1'b0) begin errors++; $display("FAIL fwd_r0: got %0b expected 0", fwd_rs2); end
    rd_M = 5'd4;
    #1;
    checks++; if (fwd_rs1 !== 1'b1) begin errors++; $display("FAIL fwd_rs1_hit: got %0b expected 1", fwd_rs1); end
    clr_inputs();
    #1;
  endtask

  task automatic test_flush_hold2();
    cyc();
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd8; rs1_F = 5'd8; branch_D = 1'b1;
    cyc(); exp_sc++;
    MemRead_E = 1'b0; RegWrite_E = 1'b0; rd_E = 5'd0;
    RegWrite_M = 1'b1; rd_M = 5'd8; mispredict_E = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_busy: got %0b expected 1", busy); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fl_flush: got %0b expected 1", flush); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %0b expected 0", stall); end
    checks++; if (fwd_rs1 !== 1'b0) begin errors++; $display("FAIL fl_fwd_rs1: got %0b expected 0", fwd_rs1); end
    cyc(); exp_fc++;
    clr_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_run: got %0b expected 0", busy); end
    checks++; if (flush_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL fl_flush_cnt: got %0d expected %0d", flush_cnt, exp_fc); end
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errors++; $display("FAIL fl_stall_cnt: got %0d expected %0d", stall_cnt, exp_sc); end
    // jr redirect suppresses a load-use stall.
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd5; rs1_F = 5'd5; jr_E = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL jr_arb: got stall=%0b flush=%0b expected stall=0 flush=1", stall, flush); end
    cyc(); exp_fc++;
    clr_inputs();
    #1;
    checks++; if (flush_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL jr_flush_cnt: got %0d expected %0d", flush_cnt, exp_fc); end
  endtask

  task automatic test_async_reset();
    cyc();
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd8; rs1_F = 5'd8; branch_D = 1'b1;
    cyc(); exp_sc++;
    clr_inputs();
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_pre_busy: got %0b expected 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %0b expected 0", busy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL ar_flush_cnt: got %0d expected 0", flush_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %0b expected 0", stall); end
    #1 reset = 1'b0;
    exp_sc = 0; exp_fc = 0; exp_sc4 = 0;
    #1;
  endtask

  task automatic test_saturation();
    cyc();
    MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd5; rs1_F = 5'd5;
    for (int i = 0; i < 20; i++) begin
      cyc();
      exp_sc++;
      exp_sc4 = (exp_sc4 < 15) ? exp_sc4 + 1 : 15;
    end
    clr_inputs();
    #1;
    checks++; if (stall_cnt4 !== 4'(exp_sc4)) begin errors++; $display("FAIL sat_cnt4: got %0d expected %0d", stall_cnt4, exp_sc4); end
    checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4_max: got %0d expected 15", stall_cnt4); end
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errors++; $display("FAIL sat_cnt16: got %0d expected %0d", stall_cnt, exp_sc); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL sat_busy4: got %0b expected 0", busy4); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_forward();
    test_flush_hold2();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
